uart_rx_os: RTL

16x-oversampling UART receiver, the receive-side counterpart of the team's UART transmitter, sharing the same baud-tick generator and frame format: 1 start bit, DBIT data bits LSB first, no parity, stop-bit length set by SB_TICK. It synchronises the asynchronous serial line and validates the start bit at mid-bit. It samples each data bit at its centre, checks the stop bit, and presents the assembled word with a one-cycle completion strobe and a framing-error flag. It sits between the pad-side `rx` line and the UART FIFO/consumer logic.

---
 rtl/uart_rx_os.sv | 119 +++++++++++
 1 files changed

// File: rtl/uart_rx_os.sv
// 16x-oversampling UART receiver: 1 start bit, DBIT data bits LSB first, no parity,
// stop length set by SB_TICK. Emits the received word with a one-cycle done strobe.
module uart_rx_os #(
  parameter int DBIT    = 8,   // 5..8
  parameter int SB_TICK = 16   // 16, 24 or 32
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       rx,
  input  logic       s_tick,
  output logic [7:0] dout,
  output logic       rx_done_tick,
  output logic       frame_err
);

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } state_e;

  localparam logic [2:0] N_LAST = 3'(DBIT - 1);
  localparam logic [4:0] S_LAST = 5'(SB_TICK - 1);

  state_e     state_q;
  logic       rx_meta_q;
  logic       rx_s_q;
  logic [4:0] s_q;
  logic [2:0] n_q;
  logic [7:0] b_q;
  logic [7:0] dout_q;
  logic       done_q;
  logic       ferr_q;

  // Synchroniser resets to the idle line level so reset release never looks like a start edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
    end else begin
      // NOTE: non-blocking assignments so every flop samples the pre-edge value of its source.
      rx_meta_q <= rx;
      rx_s_q    <= rx_meta_q;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      // NOTE: the shift register and output word are reset too, so an aborted frame leaves no residue.
      state_q <= IDLE;
      s_q     <= '0;
      n_q     <= '0;
      b_q     <= '0;
      dout_q  <= '0;
      done_q  <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (!rx_s_q) begin
            state_q <= START;
            s_q     <= '0;
          end
        end
        START: begin
          if (s_tick) begin
            if (s_q == 5'd7) begin
              if (!rx_s_q) begin
                state_q <= DATA;
                s_q     <= '0;
                n_q     <= '0;
              end else begin
                state_q <= IDLE;  // line back high at mid start bit: glitch
              end
            end else begin
              s_q <= s_q + 5'd1;
            end
          end
        end
        DATA: begin
          if (s_tick) begin
            if (s_q == 5'd15) begin
              b_q <= {rx_s_q, b_q[7:1]};
              s_q <= '0;
              if (n_q == N_LAST) begin
                state_q <= STOP;
              end else begin
                n_q <= n_q + 3'd1;
              end
            end else begin
              s_q <= s_q + 5'd1;
            end
          end
        end
        STOP: begin
          if (s_tick) begin
            if (s_q == S_LAST) begin
              // Leaving mid stop bit lets the next start edge be caught early.
              state_q <= IDLE;
              dout_q  <= b_q >> (8 - DBIT);
              ferr_q  <= ~rx_s_q;
              done_q  <= 1'b1;
            end else begin
              s_q <= s_q + 5'd1;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign dout         = dout_q;
  assign rx_done_tick = done_q;
  assign frame_err    = ferr_q;

endmodule
